pipe_skid_reg: RTL and testbench



---
 rtl/pipe_skid_reg_pkg.sv | 31 +++
 rtl/pipe_skid_reg_if.sv | 38 +++
 rtl/pipe_skid_reg_dffe_n.sv | 37 +++
 rtl/pipe_skid_reg.sv | 141 ++++++++++++++
 tb/tb_pipe_skid_reg.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_skid_reg_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipe_skid_reg pipeline stage.
//   OCC_W   : width of the state register and of the occupancy output
//   state_e : handshake state; its encoding is the number of held beats
//             (EMPTY=0, FULL=1, SKID=2), so occupancy is the state itself.
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [OCC_W-1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  // Beats held in a given state; the unused code 3 reports as a single beat
  // so that downstream logic never sees an out-of-range count.
  function automatic logic [OCC_W-1:0] occ_of(input state_e st);
    logic [OCC_W-1:0] occ;
    case (st)
      ST_EMPTY: occ = 2'd0;
      ST_FULL:  occ = 2'd1;
      ST_SKID:  occ = 2'd2;
      default:  occ = 2'd1;
    endcase
    return occ;
  endfunction

endpackage : pipe_pkg

// File: rtl/pipe_skid_reg_if.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg_if
// Handshake bundle of one pipeline stage boundary.
//   flush      : synchronous discard of all held beats (producer side)
//   in_valid   : upstream beat present
//   in_ready   : stage can accept a beat this cycle
//   in_data    : upstream payload
//   out_valid  : beat present on out_data
//   out_ready  : downstream accepts this cycle
//   out_data   : payload from the main register
//   occupancy  : number of held beats (0..2)
// Modports: slave = the stage itself, master = the environment around it.
// -----------------------------------------------------------------------------
interface pipe_skid_reg_if #(
  parameter int WIDTH = 16
);
  import pipe_pkg::*;

  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [OCC_W-1:0]     occupancy;

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

endinterface : pipe_skid_reg_if

// File: rtl/pipe_skid_reg_dffe_n.sv
// -----------------------------------------------------------------------------
// dffe_n
// WIDTH-bit register with synchronous active-high reset to RESET_VAL and a
// load enable. Reset has priority over the enable.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   en_i  : load d_i on the next rising edge
//   d_i   : next value
//   q_o   : registered value
// -----------------------------------------------------------------------------
module dffe_n #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  // Storage element: reset, load or hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= RESET_VAL;
    end else if (en_i) begin
      q_q <= d_i;
    end else begin
      q_q <= q_q;
    end
  end

  assign q_o = q_q;

endmodule : dffe_n

// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
// Pipeline register with valid/ready handshake and a one-entry skid buffer.
// A beat accepted in cycle N appears on out_data in cycle N+1. in_ready is a
// function of the state register only, so there is no combinational path from
// out_ready to in_ready; the skid register absorbs the one beat that arrives
// in the cycle where downstream first stalls.
//   clk : clock, rising edge
//   rst : synchronous active-high reset (priority over flush and handshake)
//   bus : pipe_skid_reg_if.slave handshake bundle (see interface header)
// -----------------------------------------------------------------------------
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  pipe_skid_reg_if.slave        bus
);

  logic [OCC_W-1:0] state_raw_q;
  state_e           state_q;
  state_e           state_d;

  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] main_d;
  logic             main_en;
  logic             main_from_skid;

  logic [WIDTH-1:0] skid_q;
  logic             skid_en;

  logic             in_ready;
  logic             out_valid;
  logic             in_xfer;
  logic             out_xfer;

  assign state_q   = state_e'(state_raw_q);

  // Handshake outputs depend on the state register only.
  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = (state_q != ST_SKID);
  assign in_xfer   = bus.in_valid && in_ready;
  assign out_xfer  = out_valid && bus.out_ready;

  // Next-state and data-register load enables.
  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    main_from_skid = 1'b0;
    skid_en        = 1'b0;

    if (bus.flush) begin
      // Held beats and any beat offered this cycle are dropped; the data
      // registers keep their (now stale) contents.
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_en = 1'b1;
            state_d = ST_FULL;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (in_xfer && out_xfer) begin
            main_en = 1'b1;
            state_d = ST_FULL;
          end else if (in_xfer) begin
            // Downstream stalled with a new beat arriving: park it.
            skid_en = 1'b1;
            state_d = ST_SKID;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_FULL;
          end
        end
        ST_SKID: begin
          // in_ready is low here, so only the drain of main matters.
          if (out_xfer) begin
            main_en        = 1'b1;
            main_from_skid = 1'b1;
            state_d        = ST_FULL;
          end else begin
            state_d = ST_SKID;
          end
        end
        default: begin
          // Unused encoding: recover to a known empty stage.
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_q : bus.in_data;

  dffe_n #(
    .WIDTH     (OCC_W),
    .RESET_VAL (ST_EMPTY)
  ) u_state (
    .clk  (clk),
    .rst  (rst),
    .en_i (1'b1),
    .d_i  (state_d),
    .q_o  (state_raw_q)
  );

  dffe_n #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_main (
    .clk  (clk),
    .rst  (rst),
    .en_i (main_en),
    .d_i  (main_d),
    .q_o  (main_q)
  );

  dffe_n #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_skid (
    .clk  (clk),
    .rst  (rst),
    .en_i (skid_en),
    .d_i  (bus.in_data),
    .q_o  (skid_q)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = main_q;
  assign bus.occupancy = occ_of(state_q);

endmodule : pipe_skid_reg

// File: tb/tb_pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_reg
// Three instances of pipe_skid_reg (16-bit/reset 0, 8-bit/reset 0x5A,
// 32-bit/reset 0) driven one at a time and compared each cycle against a
// reference model: an up-to-two-entry FIFO plus the value last shown on
// out_data (which holds while the stage is empty).
// -----------------------------------------------------------------------------
module tb_pipe_skid_reg;

  logic clk;
  logic rst16;
  logic rst8;
  logic rst32;

  int errors;
  int checks;
  int tot_in;
  int tot_out;

  // Reference model per instance: FIFO contents, fill level, last shown value.
  logic [31:0] mbuf  [0:2][0:1];
  int          mcnt  [0:2];
  logic [31:0] mlast [0:2];

  pipe_skid_reg_if #(.WIDTH(16)) if16 ();
  pipe_skid_reg_if #(.WIDTH(8))  if8  ();
  pipe_skid_reg_if #(.WIDTH(32)) if32 ();

  pipe_skid_reg #(.WIDTH(16), .RESET_VAL(16'h0000)) dut16 (.clk(clk), .rst(rst16), .bus(if16));
  pipe_skid_reg #(.WIDTH(8),  .RESET_VAL(8'h5A))    dut8  (.clk(clk), .rst(rst8),  .bus(if8));
  pipe_skid_reg #(.WIDTH(32), .RESET_VAL(32'h0))    dut32 (.clk(clk), .rst(rst32), .bus(if32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] width_mask(input int id);
    case (id)
      0:       return 32'h0000_FFFF;
      1:       return 32'h0000_00FF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] reset_val(input int id);
    case (id)
      1:       return 32'h0000_005A;
      default: return 32'h0000_0000;
    endcase
  endfunction

  task automatic idle_all();
    rst16 = 1'b0; rst8 = 1'b0; rst32 = 1'b0;
    if16.flush = 1'b0; if16.in_valid = 1'b0; if16.in_data = 16'h0; if16.out_ready = 1'b0;
    if8.flush  = 1'b0; if8.in_valid  = 1'b0; if8.in_data  = 8'h0;  if8.out_ready  = 1'b0;
    if32.flush = 1'b0; if32.in_valid = 1'b0; if32.in_data = 32'h0; if32.out_ready = 1'b0;
  endtask

  // One clock of stimulus on instance id, with checks of the outputs seen
  // before the edge and a model update for the edge itself.
  task automatic cycle(input int id, input bit r, input bit f, input bit iv,
                       input logic [31:0] din, input bit ordy, input string tag);
    logic [31:0] od;
    logic [31:0] exp_d;
    logic        ov;
    logic        ir;
    logic [1:0]  occ;
    logic [1:0]  exp_occ;
    bit          in_x;
    bit          out_x;
    idle_all();
    case (id)
      0: begin rst16 = r; if16.flush = f; if16.in_valid = iv; if16.in_data = din[15:0]; if16.out_ready = ordy; end
      1: begin rst8  = r; if8.flush  = f; if8.in_valid  = iv; if8.in_data  = din[7:0];  if8.out_ready  = ordy; end
      default: begin rst32 = r; if32.flush = f; if32.in_valid = iv; if32.in_data = din; if32.out_ready = ordy; end
    endcase
    case (id)
      0: begin od = {16'h0, if16.out_data}; ov = if16.out_valid; ir = if16.in_ready; occ = if16.occupancy; end
      1: begin od = {24'h0, if8.out_data};  ov = if8.out_valid;  ir = if8.in_ready;  occ = if8.occupancy;  end
      default: begin od = if32.out_data; ov = if32.out_valid; ir = if32.in_ready; occ = if32.occupancy; end
    endcase

    exp_d   = (mcnt[id] > 0) ? mbuf[id][0] : mlast[id];
    exp_occ = 2'(mcnt[id]);

    checks++;
    if (ov !== (mcnt[id] > 0)) begin
      errors++;
      $display("FAIL %s out_valid: got %b want %b", tag, ov, (mcnt[id] > 0));
    end
    checks++;
    if (ir !== (mcnt[id] < 2)) begin
      errors++;
      $display("FAIL %s in_ready: got %b want %b", tag, ir, (mcnt[id] < 2));
    end
    checks++;
    if (occ !== exp_occ) begin
      errors++;
      $display("FAIL %s occupancy: got %0d want %0d", tag, occ, exp_occ);
    end
    checks++;
    if (od !== exp_d) begin
      errors++;
      $display("FAIL %s out_data: got %h want %h", tag, od, exp_d);
    end
    if (iv && occ === 2'd2) begin
      checks++;
      if (ir !== 1'b0) begin
        errors++;
        $display("FAIL %s skid_accept: in_ready got %b want 0 with two beats held", tag, ir);
      end
    end

    in_x  = iv && (mcnt[id] < 2);
    out_x = ordy && (mcnt[id] > 0);
    if (r) begin
      mcnt[id]  = 0;
      mlast[id] = reset_val(id);
    end else if (f) begin
      mcnt[id] = 0;
    end else begin
      if (out_x) begin
        mbuf[id][0] = mbuf[id][1];
        mcnt[id]    = mcnt[id] - 1;
        tot_out++;
      end
      if (in_x) begin
        mbuf[id][mcnt[id]] = din & width_mask(id);
        mcnt[id]           = mcnt[id] + 1;
        tot_in++;
      end
    end
    if (mcnt[id] > 0) mlast[id] = mbuf[id][0];

    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_all();
    rst16 = 1'b1; rst8 = 1'b1; rst32 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    idle_all();
    for (int i = 0; i < 3; i++) begin
      mcnt[i]  = 0;
      mlast[i] = reset_val(i);
    end
    for (int i = 0; i < 3; i++) cycle(i, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, "reset_idle");
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 8; i++) cycle(0, 1'b0, 1'b0, 1'b1, 32'(i), 1'b1, "stream");
    repeat (2) cycle(0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, "stream_drain");
  endtask

  task automatic test_back_pressure();
    cycle(0, 1'b0, 1'b0, 1'b1, 32'hAAAA, 1'b0, "bp_a");
    cycle(0, 1'b0, 1'b0, 1'b1, 32'hBBBB, 1'b0, "bp_b");
    cycle(0, 1'b0, 1'b0, 1'b1, 32'hCCCC, 1'b0, "bp_c_ignored");
    cycle(0, 1'b0, 1'b0, 1'b1, 32'hCCCC, 1'b1, "bp_deliver_a");
    cycle(0, 1'b0, 1'b0, 1'b1, 32'hCCCC, 1'b1, "bp_deliver_b");
    repeat (2) cycle(0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, "bp_drain");
  endtask

  task automatic test_flush_skid();
    cycle(0, 1'b0, 1'b0, 1'b1, 32'h1111, 1'b0, "fl_fill1");
    cycle(0, 1'b0, 1'b0, 1'b1, 32'h2222, 1'b0, "fl_fill2");
    cycle(0, 1'b0, 1'b1, 1'b1, 32'h1234, 1'b0, "fl_flush");
    repeat (3) cycle(0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, "fl_after");
  endtask

  task automatic test_reset_priority();
    cycle(1, 1'b0, 1'b0, 1'b1, 32'h33, 1'b0, "rp_fill");
    cycle(1, 1'b1, 1'b1, 1'b1, 32'h77, 1'b0, "rp_rst_flush");
    repeat (2) cycle(1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, "rp_after");
  endtask

  task automatic test_random();
    tot_in  = 0;
    tot_out = 0;
    for (int i = 0; i < 10000; i++) begin
      cycle(2, 1'b0, 1'b0, bit'($urandom_range(1, 0)), $urandom(),
            bit'($urandom_range(1, 0)), "rand");
    end
    checks++;
    if (int'(if32.occupancy) !== (tot_in - tot_out)) begin
      errors++;
      $display("FAIL rand_balance occupancy: got %0d want %0d", if32.occupancy, tot_in - tot_out);
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    tot_in  = 0;
    tot_out = 0;
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush_skid();
    test_reset_priority();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pipe_skid_reg
